// File: rtl/tl_ul_sram_responder_pkg.sv
// TileLink-UL opcode constants, channel widths and alignment helper shared by the
// SRAM responder and its storage array.
package tl_ul_sram_responder_pkg;

   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_SZW = 2;
   localparam int TL_MW  = TL_DW / 8;

   typedef enum logic [2:0] {
      A_PUT_FULL    = 3'd0,
      A_PUT_PARTIAL = 3'd1,
      A_ARITHMETIC  = 3'd2,
      A_LOGICAL     = 3'd3,
      A_GET         = 3'd4,
      A_INTENT      = 3'd5
   } tl_a_op_e;

   typedef enum logic [2:0] {
      D_ACCESS_ACK      = 3'd0,
      D_ACCESS_ACK_DATA = 3'd1,
      D_HINT_ACK        = 3'd2
   } tl_d_op_e;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

   // Sizes above one word are never aligned for a 32-bit responder.
   function automatic logic size_aligned(input logic [1:0] addr_lo, input logic [TL_SZW-1:0] size);
      logic ok;
      ok = 1'b0;
      case (size)
         2'd0:    ok = 1'b1;
         2'd1:    ok = (addr_lo[0] == 1'b0);
         2'd2:    ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/tl_ul_sram_responder_sram_array.sv
// Word storage: one byte-wide memory per lane, synchronous masked write,
// combinational read, contents never reset.
module tl_sram_array
   import tl_ul_sram_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int IDX_W       = 6
) (
   input  logic             clock,
   input  logic             we,
   input  logic [IDX_W-1:0] addr,
   input  logic [TL_MW-1:0] wmask,
   input  logic [TL_DW-1:0] wdata,
   output logic [TL_DW-1:0] rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < TL_MW; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];

         always_ff @(posedge clock) begin
            if (we && wmask[gi]) begin
               mem[addr] <= wdata[8*gi +: 8];
            end
         end

         assign rdata[8*gi +: 8] = mem[addr];
      end
   endgenerate

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TL-UL slave fronting a small SRAM: single response register, one request per
// cycle, illegal or unsupported accesses answered with d_denied.
module tl_ul_sram_responder
   import tl_ul_sram_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 64,
   parameter int          SOURCE_W    = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [2:0]          a_opcode,
   input  logic [2:0]          a_param,
   input  logic [TL_SZW-1:0]   a_size,
   input  logic [SOURCE_W-1:0] a_source,
   input  logic [TL_AW-1:0]    a_address,
   input  logic [TL_MW-1:0]    a_mask,
   input  logic [TL_DW-1:0]    a_data,
   output logic                d_valid,
   input  logic                d_ready,
   output logic [2:0]          d_opcode,
   output logic [1:0]          d_param,
   output logic [TL_SZW-1:0]   d_size,
   output logic [SOURCE_W-1:0] d_source,
   output logic                d_denied,
   output logic [TL_DW-1:0]    d_data,
   output logic                d_corrupt
);

   localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

   rsp_state_e          state_q, state_d;
   logic [2:0]          d_opcode_q, d_opcode_d;
   logic [TL_SZW-1:0]   d_size_q, d_size_d;
   logic [SOURCE_W-1:0] d_source_q, d_source_d;
   logic                d_denied_q, d_denied_d;
   logic [TL_DW-1:0]    d_data_q, d_data_d;
   logic                d_corrupt_q, d_corrupt_d;

   logic [31:0]      offset;
   logic             in_range, legal, a_fire, wr_en;
   logic [IDX_W-1:0] word_idx;
   logic [TL_DW-1:0] rd_word;
   logic [2:0]       rsp_opcode;
   logic             rsp_denied, rsp_corrupt;
   logic [TL_DW-1:0] rsp_data;
   logic             unused_bits;

   // Range test uses the wrapped offset so addresses below BASE_ADDR fail too.
   assign offset   = a_address - BASE_ADDR;
   assign in_range = (a_address >= BASE_ADDR) && (offset < SPAN_BYTES);
   assign word_idx = offset[IDX_W+1:2];
   assign legal    = in_range && size_aligned(offset[1:0], a_size);

   assign a_ready = (state_q == RSP_EMPTY) || d_ready;
   assign a_fire  = a_valid && a_ready;

   always_comb begin
      rsp_opcode  = D_ACCESS_ACK;
      rsp_denied  = 1'b1;
      rsp_corrupt = 1'b0;
      rsp_data    = '0;
      wr_en       = 1'b0;
      case (a_opcode)
         A_GET: begin
            rsp_opcode  = D_ACCESS_ACK_DATA;
            rsp_denied  = !legal;
            rsp_corrupt = !legal;
            rsp_data    = legal ? rd_word : '0;
         end
         A_PUT_FULL, A_PUT_PARTIAL: begin
            rsp_denied = !legal;
            wr_en      = a_fire && legal;
         end
         A_ARITHMETIC, A_LOGICAL: begin
            rsp_opcode  = D_ACCESS_ACK_DATA;
            rsp_corrupt = 1'b1;
         end
         A_INTENT: begin
            rsp_opcode = D_HINT_ACK;
            rsp_denied = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      d_opcode_d  = d_opcode_q;
      d_size_d    = d_size_q;
      d_source_d  = d_source_q;
      d_denied_d  = d_denied_q;
      d_data_d    = d_data_q;
      d_corrupt_d = d_corrupt_q;
      if (a_fire) begin
         state_d     = RSP_FULL;
         d_opcode_d  = rsp_opcode;
         d_size_d    = a_size;
         d_source_d  = a_source;
         d_denied_d  = rsp_denied;
         d_data_d    = rsp_data;
         d_corrupt_d = rsp_corrupt;
      end else if ((state_q == RSP_FULL) && d_ready) begin
         state_d = RSP_EMPTY;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= RSP_EMPTY;
         d_opcode_q  <= '0;
         d_size_q    <= '0;
         d_source_q  <= '0;
         d_denied_q  <= 1'b0;
         d_data_q    <= '0;
         d_corrupt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_opcode_q  <= d_opcode_d;
         d_size_q    <= d_size_d;
         d_source_q  <= d_source_d;
         d_denied_q  <= d_denied_d;
         d_data_q    <= d_data_d;
         d_corrupt_q <= d_corrupt_d;
      end
   end

   tl_sram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clock (clock),
      .we    (wr_en),
      .addr  (word_idx),
      .wmask (a_mask),
      .wdata (a_data),
      .rdata (rd_word)
   );

   assign d_valid   = (state_q == RSP_FULL);
   assign d_opcode  = d_opcode_q;
   assign d_param   = 2'b00;
   assign d_size    = d_size_q;
   assign d_source  = d_source_q;
   assign d_denied  = d_denied_q;
   assign d_data    = d_data_q;
   assign d_corrupt = d_corrupt_q;

   assign unused_bits = ^{a_param, offset[31:IDX_W+2]};

endmodule

// File: doc/tl_ul_sram_responder.md
TL_UL_SRAM_RESPONDER -- requirements
Module: tl_ul_sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of storage word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit storage words (power of two).
REQ-003 SHALL have parameter SOURCE_W, default 1, width of the source ID.
REQ-004 SHALL have these ports (name direction width meaning):
 clock  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-high reset
 a_valid  in  1  request valid
 a_ready  out  1  request accepted when a_valid && a_ready
 a_opcode  in  3  TL-UL A opcode
 a_param  in  3  ignored
 a_size  in  2  log2 bytes
 a_source  in  SOURCE_W  request ID
 a_address  in  32  byte address
 a_mask  in  4  byte lanes
 a_data  in  32  write data
 d_valid  out  1  response valid
 d_ready  in  1  response accepted when d_valid && d_ready
 d_opcode  out  3  TL-UL D opcode
 d_param  out  2  always 0
 d_size  out  2  echo of a_size
 d_source  out  SOURCE_W  echo of a_source
 d_denied  out  1  request refused
 d_data  out  32  read data
 d_corrupt  out  1  d_data invalid

Function
REQ-005 SHALL hold one response register; states EMPTY (d_valid=0) and FULL (d_valid=1).
REQ-006 SHALL drive a_ready = !d_valid || d_ready, combinationally, with no dependency on a_valid.
REQ-007 SHALL present each response exactly one cycle after its A fire: EMPTY->FULL on fire; FULL->EMPTY on D fire without A fire; FULL stays FULL when A and D fire in the same cycle; throughput is one request per cycle.
REQ-008 SHALL hold all d_* outputs stable while d_valid && !d_ready.
REQ-009 SHALL decode a request as in range when BASE_ADDR <= a_address < BASE_ADDR+4*DEPTH_WORDS; word index = (a_address-BASE_ADDR)>>2.
REQ-010 SHALL classify a request as legal when it is in range, a_size<=2, and a_address is aligned to 2^a_size.
REQ-011 Get(4): SHALL respond AccessAckData(1) with the word at acceptance time; if illegal, d_denied=1, d_corrupt=1, d_data=0.
REQ-012 PutFullData(0)/PutPartialData(1): SHALL respond AccessAck(0); if legal, SHALL write a_data bytes selected by a_mask in the fire cycle; if illegal, SHALL suppress the write and set d_denied=1.
REQ-013 ArithmeticData(2)/LogicalData(3): SHALL respond AccessAckData, d_denied=1, d_corrupt=1, d_data=0, and SHALL NOT write.
REQ-014 Intent(5): SHALL respond HintAck(2), not denied, with no storage effect.
REQ-015 Opcodes 6 and 7: SHALL respond AccessAck, d_denied=1.
REQ-016 A Get accepted in the cycle after a Put to the same word SHALL return the Put data; the write commits in the fire cycle.
REQ-017 d_corrupt SHALL be 0 on every non-data response; d_data SHALL be 0 on every non-AccessAckData response.

Reset
REQ-018 On reset assertion, asynchronously: state EMPTY, d_valid=0, d_opcode/d_size/d_source/d_data=0, d_denied=0, d_corrupt=0; a_ready=1 after release.
REQ-019 Reset mid-response SHALL drop the pending response; storage contents SHALL NOT be reset and SHALL be retained.

Structure
REQ-020 SHALL take TL-UL A/D opcode constants and widths from the shared TileLink package; BASE_ADDR and DEPTH_WORDS stay module parameters.
REQ-021 Storage SHALL be one sub-module, tl_sram_array: synchronous byte-masked write, combinational read, no reset.

Verification
REQ-022 Put addr 0x8000_0000 data 0xDEAD_BEEF mask 0xF, then Get same address -> AccessAck, then AccessAckData 0xDEAD_BEEF, not denied.
REQ-023 PutPartial mask 0x3 data 0x1234_5678 over word 0xFFFF_FFFF -> following Get returns 0xFFFF_5678.
REQ-024 Get addr 0x8000_0100 (DEPTH_WORDS=64) -> d_denied=1, d_corrupt=1, d_data=0; Put there leaves all storage unchanged.
REQ-025 Hold d_ready=0 for 5 cycles with a_valid=1 -> a_ready=0 and d_* stable; raise d_ready -> back-to-back Gets, one response per cycle, sources in order.
REQ-026 Get with a_size=2, address 0x8000_0002 -> denied; Intent -> HintAck, not denied; opcode 7 -> AccessAck denied.
REQ-027 Assert reset while d_valid=1 -> d_valid=0 immediately; a Get after reset returns the pre-reset data.
